dmem_responder: RTL

Data-memory responder that sits on the far side of the pipeline's data-memory port and answers the datapath's load/store requests. It accepts one request at a time: a byte address, 4-bit byte-lane write enables and write data. After a configurable number of wait states it completes the request with a one-cycle acknowledge. Stores merge only the enabled byte lanes. Loads return the full aligned word; byte/halfword extraction stays in the datapath's read-side logic.

---
 rtl/dmem_pkg.sv | 13 +
 rtl/bytewrite_ram.sv | 32 +++
 rtl/dmem_responder.sv | 121 ++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  localparam int CNT_W      = 4;
  localparam int BYTE_LANES = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK
  } state_t;

endpackage

// File: rtl/bytewrite_ram.sv
// Word-wide RAM with per-byte write lanes, synchronous write and registered read.
module bytewrite_ram
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [BYTE_LANES-1:0] lane_en,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           q
);

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  // Disabled lanes keep their old byte; q only moves on a read strobe.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < BYTE_LANES; i++) begin
        if (lane_en[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
    if (rd_en) begin
      q <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store, waits WAIT_CYCLES, then
// commits to the RAM and pulses ack_o for one cycle.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic [3:0]  we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        ack_o,
  output logic        err_o,
  output logic        busy_o
);

  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       we_q;
  logic [29:0]      addr_q;
  logic [31:0]      wdata_q;
  logic             rd_zero;
  logic [31:0]      ram_q;

  logic             commit;
  logic [3:0]       c_we;
  logic [29:0]      c_addr;
  logic [31:0]      c_wdata;
  logic             c_oor;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^addr_i[1:0];

  // With zero wait states the commit edge is the accept edge, so the live
  // request fields feed the RAM instead of the (not yet loaded) latch.
  always_comb begin
    commit  = 1'b0;
    c_we    = we_q;
    c_addr  = addr_q;
    c_wdata = wdata_q;
    case (state)
      ST_IDLE: begin
        if (req_i && WAIT_CYCLES == 0) begin
          commit  = 1'b1;
          c_we    = we_i;
          c_addr  = addr_i[31:2];
          c_wdata = wdata_i;
        end
      end
      ST_WAIT: commit = (cnt == CNT_ONE);
      default: commit = 1'b0;
    endcase
    if (rst) begin
      commit = 1'b0;
    end
  end

  assign c_oor = |c_addr[29:ADDR_W];

  bytewrite_ram #(
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk    (clk),
    .wr_en  (commit && (c_we != 4'b0000) && !c_oor),
    .lane_en(c_we),
    .rd_en  (commit && (c_we == 4'b0000) && !c_oor),
    .addr   (c_addr[ADDR_W-1:0]),
    .wdata  (c_wdata),
    .q      (ram_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      we_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      ack_o   <= 1'b0;
      err_o   <= 1'b0;
      rd_zero <= 1'b1;
    end else begin
      ack_o <= commit;
      err_o <= commit && c_oor;
      // rd_zero masks the RAM output after reset and after out-of-range reads.
      if (commit && c_we == 4'b0000) begin
        rd_zero <= c_oor;
      end
      case (state)
        ST_IDLE: begin
          if (req_i) begin
            we_q    <= we_i;
            addr_q  <= addr_i[31:2];
            wdata_q <= wdata_i;
            cnt     <= WAIT_INIT;
            state   <= (WAIT_CYCLES == 0) ? ST_ACK : ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_ONE) begin
            state <= ST_ACK;
          end
        end
        ST_ACK:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign rdata_o = rd_zero ? 32'h0 : ram_q;
  assign busy_o  = req_i & ~ack_o;

endmodule
